// File: rtl/conv_result_writer_if.sv
// Result-pair handshake between the convolution engine (master) and the
// result writer (slave). The engine holds a pair stable until o_ready is seen.
interface conv_result_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_sum1;
  logic [DATA_W-1:0] i_sum2;
  logic [ADDR_W-1:0] i_dest_addr1;
  logic [ADDR_W-1:0] i_dest_addr2;

  modport master (
    output i_valid, i_sum1, i_sum2, i_dest_addr1, i_dest_addr2,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_sum1, i_sum2, i_dest_addr1, i_dest_addr2,
    output o_ready
  );
endinterface

// File: rtl/conv_result_writer.sv
// conv_result_writer: buffers convolution result pairs in a small FIFO and
// serialises each pair into two writes on the feature RAM's single write port.
// Pulses o_done once every accepted pair has been committed after i_done.
// Optional macro CONV_WR_ADDR_CHECK_EN: suppress writes to addresses beyond
// ROWS*COLS and raise a sticky o_err.
module conv_result_writer #(
  parameter int ROWS   = 28,
  parameter int COLS   = 28,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  conv_result_writer_if.slave  res,
  input  logic                 i_done,
  output logic                 o_wr_en,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [DATA_W-1:0]    o_wr_data,
  output logic                 o_done,
  output logic [15:0]          o_wr_count,
  output logic                 o_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int unsigned RAM_DEPTH = ROWS * COLS;
`ifdef CONV_WR_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [DATA_W-1:0] s1;
    logic [DATA_W-1:0] s2;
  } pair_t;

  typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

  pair_t             mem [DEPTH];
  pair_t             head;
  pair_t             hold;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              done_pending;
  state_t            state;

  // Address is out of the RAM's range; always false when the check is off.
  function automatic logic bad_addr(input logic [ADDR_W-1:0] a);
    return CHECK_EN && (32'(a) >= RAM_DEPTH);
  endfunction

  // Ready is derived from the pre-pop count, so a full FIFO never takes a
  // push even when a pop happens in the same cycle.
  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign res.o_ready = !full;
  assign push        = res.i_valid && !full;
  assign pop         = !empty && ((state == IDLE) || (state == WR2));
  assign head        = mem[rd_ptr];

  // Pair storage; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{a1: res.i_dest_addr1, a2: res.i_dest_addr2,
                       s1: res.i_sum1,       s2: res.i_sum2};
  end

  // FIFO pointers wrap naturally; count carries the extra bit for full/empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Write sequencer: outputs are registered alongside the state so the RAM
  // port never sees combinational glitches; idle cycles drive zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hold      <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      case (state)
        IDLE, WR2: begin
          if (pop) begin
            hold  <= head;
            state <= WR1;
            if (!bad_addr(head.a1)) begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= head.a1;
              o_wr_data <= head.s1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WR1: begin
          state <= WR2;
          if (!bad_addr(hold.a2)) begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= hold.a2;
            o_wr_data <= hold.s2;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issued-write counter; a write coinciding with i_start opens the new run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      o_wr_count <= '0;
    else if (i_start)
      o_wr_count <= {15'd0, o_wr_en};
    else if (o_wr_en && (o_wr_count != 16'hFFFF))
      o_wr_count <= o_wr_count + 16'd1;
  end

  // Done fires once the pipeline is fully drained and nothing new arrives.
  assign o_done = done_pending && empty && (state == IDLE) && !push;

  // Remember the producer's last-pair notice until the drain completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      done_pending <= 1'b0;
    else if (i_start || o_done)
      done_pending <= 1'b0;
    else if (i_done)
      done_pending <= 1'b1;
  end

`ifdef CONV_WR_ADDR_CHECK_EN
  logic wr_bad;
  assign wr_bad = (pop && bad_addr(head.a1)) ||
                  ((state == WR1) && bad_addr(hold.a2));

  // Sticky error; a bad write in the same cycle as i_start still flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      o_err <= 1'b0;
    else if (wr_bad)
      o_err <= 1'b1;
    else if (i_start)
      o_err <= 1'b0;
  end
`else
  assign o_err = 1'b0;
`endif

endmodule
